// File: rtl/md_defs.sv
// -----------------------------------------------------------------------------
// md_defs
//   Shared definitions for the multiply/divide unit of the E stage:
//   md op encodings, controller FSM states and an op-class helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package md_defs;

    typedef enum logic [2:0] {
        MDOP_MULT  = 3'd0,
        MDOP_MULTU = 3'd1,
        MDOP_DIV   = 3'd2,
        MDOP_DIVU  = 3'd3,
        MDOP_MTHI  = 3'd4,
        MDOP_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // MULT/MULTU/DIV/DIVU occupy codes 0..3, i.e. bit 2 clear.
    function automatic logic is_arith(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/md_arith.sv
// -----------------------------------------------------------------------------
// md_arith
//   Combinational datapath for MULT/MULTU/DIV/DIVU.
//   Ports:
//     i_op    [2:0]   op code (md_defs encoding)
//     i_a     [31:0]  rs operand
//     i_b     [31:0]  rt operand
//     o_hi    [31:0]  HI result (product high word / remainder)
//     o_lo    [31:0]  LO result (product low word / quotient)
//     o_div0          divide op with zero divisor (result must be discarded)
// -----------------------------------------------------------------------------
module md_arith
    import md_defs::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_div0
);

    logic        w_signed;
    logic        w_is_div;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_div_b;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [63:0] w_prod;
    logic        w_res_neg;

    // Signed ops are computed on magnitudes and the sign is reapplied.
    // This also gives 0x80000000 / -1 = 0x80000000 without relying on
    // signed-division overflow behaviour.
    assign w_signed  = (i_op == MDOP_MULT) || (i_op == MDOP_DIV);
    assign w_is_div  = (i_op == MDOP_DIV)  || (i_op == MDOP_DIVU);
    assign w_mag_a   = (w_signed && i_a[31]) ? (32'd0 - i_a) : i_a;
    assign w_mag_b   = (w_signed && i_b[31]) ? (32'd0 - i_b) : i_b;
    assign w_res_neg = w_signed && (i_a[31] ^ i_b[31]);

    // Divisor forced non-zero so the divider never sees x/0.
    assign w_div_b = (i_b == '0) ? 32'd1 : w_mag_b;
    assign w_quo   = w_mag_a / w_div_b;
    assign w_rem   = w_mag_a % w_div_b;
    assign w_prod  = {32'd0, w_mag_a} * {32'd0, w_mag_b};

    always_comb begin
        o_hi   = '0;
        o_lo   = '0;
        o_div0 = w_is_div && (i_b == '0);
        if (w_is_div) begin
            o_lo = w_res_neg ? (32'd0 - w_quo) : w_quo;
            // Remainder takes the sign of the dividend.
            o_hi = (w_signed && i_a[31]) ? (32'd0 - w_rem) : w_rem;
        end else if (is_arith(i_op)) begin
            {o_hi, o_lo} = w_res_neg ? (64'd0 - w_prod) : w_prod;
        end
    end

endmodule

// File: rtl/md_ctrl.sv
// -----------------------------------------------------------------------------
// md_ctrl
//   Multi-cycle multiply/divide controller for the E stage. Owns HI/LO,
//   holds busy for a fixed latency per op and requests D-stage stalls.
//   Ports:
//     clk              clock, rising edge
//     reset            asynchronous, active-low
//     E_start          E-stage md-class instruction valid
//     E_mdop    [2:0]  op code (md_defs)
//     E_A       [31:0] rs operand
//     E_B       [31:0] rt operand
//     D_use_md         D-stage instruction uses the md unit or HI/LO
//     busy             arithmetic op in flight
//     stall_req        freeze the D-stage md instruction
//     HI        [31:0] HI register
//     LO        [31:0] LO register
// -----------------------------------------------------------------------------
module md_ctrl
    import md_defs::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        E_start,
    input  logic [2:0]  E_mdop,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_use_md,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES) + 1;

    md_state_e   r_state;
    md_state_e   w_state_nxt;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_start_arith;
    logic        w_load;
    logic        w_done;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_div0;

    assign w_start_arith = E_start && is_arith(E_mdop);

    md_arith u_arith (
        .i_op   (r_op),
        .i_a    (r_a),
        .i_b    (r_b),
        .o_hi   (w_res_hi),
        .o_lo   (w_res_lo),
        .o_div0 (w_div0)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_load      = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start_arith) begin
                    w_state_nxt = ST_RUN;
                    w_load      = 1'b1;
                    w_count_nxt = ((E_mdop == MDOP_DIV) || (E_mdop == MDOP_DIVU))
                                  ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                end
            end
            ST_RUN: begin
                // E_start is ignored here; the pipeline never issues one.
                if (r_count == CW'(1)) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                    w_done      = 1'b1;
                end else begin
                    w_count_nxt = r_count - CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (w_load) begin
                r_op <= E_mdop;
                r_a  <= E_A;
                r_b  <= E_B;
            end
        end
    end

    // HI/LO: arithmetic completion has priority; MTHI/MTLO only act in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_done) begin
            if (!w_div0) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end else if ((r_state == ST_IDLE) && E_start) begin
            if (E_mdop == MDOP_MTHI) r_hi <= E_A;
            if (E_mdop == MDOP_MTLO) r_lo <= E_A;
        end
    end

    assign busy      = (r_state == ST_RUN);
    // Includes the start cycle so the next md instruction never reads stale HI/LO.
    assign stall_req = D_use_md && (busy || w_start_arith);
    assign HI        = r_hi;
    assign LO        = r_lo;

endmodule

// File: tb/tb_md_ctrl.sv
// -----------------------------------------------------------------------------
// tb_md_ctrl
//   Directed self-checking bench for md_ctrl (MULT_CYCLES=5, DIV_CYCLES=10).
// -----------------------------------------------------------------------------
module tb_md_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        E_start;
    logic [2:0]  E_mdop;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        D_use_md;
    logic        busy;
    logic        stall_req;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_cmp = 0;
    int n_err = 0;
    logic chk_en = 1'b1;

    md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .E_start   (E_start),
        .E_mdop    (E_mdop),
        .E_A       (E_A),
        .E_B       (E_B),
        .D_use_md  (D_use_md),
        .busy      (busy),
        .stall_req (stall_req),
        .HI        (HI),
        .LO        (LO)
    );

    always #5 clk = ~clk;

    // Pipeline protocol: no md start while an op is in flight.
    always @(posedge clk) begin
        if (reset && chk_en) begin
            assert (!(E_start && busy))
            else begin
                n_err++;
                $display("FAIL protocol: E_start=1 while busy=1 at %0t", $time);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one op for a single edge; operands are scrambled afterwards so
    // only latched values can produce the right result.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        E_mdop  = op;
        E_A     = a;
        E_B     = b;
        E_start = 1'b1;
        tick;
        E_start = 1'b0;
        E_A     = 32'hA5A5_A5A5;
        E_B     = 32'h5A5A_5A5A;
    endtask

    task automatic test_reset;
        reset = 1'b0; E_start = 1'b0; E_mdop = 3'd0; E_A = '0; E_B = '0; D_use_md = 1'b1;
        #12;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", stall_req); end
        n_cmp++; if (HI !== 32'h0) begin n_err++; $display("FAIL rst_hi: got %h want 0", HI); end
        n_cmp++; if (LO !== 32'h0) begin n_err++; $display("FAIL rst_lo: got %h want 0", LO); end
        reset = 1'b1;
        D_use_md = 1'b0;
        tick;
    endtask

    task automatic test_mult;
        start_op(3'd0, 32'hFFFF_FFFE, 32'd3);
        for (int i = 0; i < MC; i++) begin
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mult_busy[%0d]: got %b want 1", i, busy); end
            tick;
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mult_done: busy got %b want 0", busy); end
        n_cmp++; if (HI !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi: got %h want ffffffff", HI); end
        n_cmp++; if (LO !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL mult_lo: got %h want fffffffa", LO); end

        start_op(3'd1, 32'hFFFF_FFFE, 32'd3);
        for (int i = 0; i < MC; i++) begin
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL multu_busy[%0d]: got %b want 1", i, busy); end
            tick;
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL multu_done: busy got %b want 0", busy); end
        n_cmp++; if (HI !== 32'h0000_0002) begin n_err++; $display("FAIL multu_hi: got %h want 00000002", HI); end
        n_cmp++; if (LO !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL multu_lo: got %h want fffffffa", LO); end
    endtask

    task automatic test_div;
        start_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        for (int i = 0; i < DC; i++) begin
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL div_busy[%0d]: got %b want 1", i, busy); end
            tick;
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL div_done: busy got %b want 0", busy); end
        n_cmp++; if (LO !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo: got %h want fffffffd", LO); end
        n_cmp++; if (HI !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi: got %h want ffffffff", HI); end

        start_op(3'd3, 32'd7, 32'd2);
        for (int i = 0; i < DC; i++) tick;
        n_cmp++; if (LO !== 32'd3) begin n_err++; $display("FAIL divu_lo: got %h want 00000003", LO); end
        n_cmp++; if (HI !== 32'd1) begin n_err++; $display("FAIL divu_hi: got %h want 00000001", HI); end
    endtask

    task automatic test_div_corner;
        start_op(3'd4, 32'h11, 32'h0);
        start_op(3'd5, 32'h22, 32'h0);
        n_cmp++; if (HI !== 32'h11) begin n_err++; $display("FAIL mthi_pre: got %h want 00000011", HI); end
        n_cmp++; if (LO !== 32'h22) begin n_err++; $display("FAIL mtlo_pre: got %h want 00000022", LO); end

        start_op(3'd2, 32'd5, 32'd0);
        for (int i = 0; i < DC; i++) begin
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL div0_busy[%0d]: got %b want 1", i, busy); end
            tick;
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL div0_done: busy got %b want 0", busy); end
        n_cmp++; if (HI !== 32'h11) begin n_err++; $display("FAIL div0_hi: got %h want 00000011", HI); end
        n_cmp++; if (LO !== 32'h22) begin n_err++; $display("FAIL div0_lo: got %h want 00000022", LO); end

        start_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        for (int i = 0; i < DC; i++) tick;
        n_cmp++; if (LO !== 32'h8000_0000) begin n_err++; $display("FAIL divovf_lo: got %h want 80000000", LO); end
        n_cmp++; if (HI !== 32'h0) begin n_err++; $display("FAIL divovf_hi: got %h want 00000000", HI); end
    endtask

    task automatic test_mthi_stall;
        // Start cycle of MULT with D_use_md: stall must already be asserted.
        D_use_md = 1'b1;
        E_mdop = 3'd0; E_A = 32'd9; E_B = 32'd9; E_start = 1'b1;
        #1;
        n_cmp++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL stall_start: got %b want 1", stall_req); end
        tick;
        E_start = 1'b0;
        for (int i = 0; i < MC; i++) begin
            if (i == MC - 1) begin
                D_use_md = 1'b0;
                #1;
                n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL stall_nouse: got %b want 0", stall_req); end
                D_use_md = 1'b1;
                #1;
            end
            n_cmp++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL stall_busy[%0d]: got %b want 1", i, stall_req); end
            tick;
        end
        n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL stall_after: got %b want 0", stall_req); end
        n_cmp++; if (LO !== 32'd81) begin n_err++; $display("FAIL mult9_lo: got %h want 00000051", LO); end

        // MTHI is not an arithmetic op: no stall, no busy.
        E_mdop = 3'd4; E_A = 32'h1234; E_start = 1'b1;
        #1;
        n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL stall_mthi: got %b want 0", stall_req); end
        tick;
        E_start = 1'b0;
        n_cmp++; if (HI !== 32'h1234) begin n_err++; $display("FAIL mthi_hi: got %h want 00001234", HI); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mthi_busy: got %b want 0", busy); end
        n_cmp++; if (LO !== 32'd81) begin n_err++; $display("FAIL mthi_lo: got %h want 00000051", LO); end

        start_op(3'd6, 32'hFFFF_0000, 32'd1);
        start_op(3'd7, 32'hFFFF_0000, 32'd1);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL unused_busy: got %b want 0", busy); end
        n_cmp++; if (HI !== 32'h1234) begin n_err++; $display("FAIL unused_hi: got %h want 00001234", HI); end
        n_cmp++; if (LO !== 32'd81) begin n_err++; $display("FAIL unused_lo: got %h want 00000051", LO); end
        D_use_md = 1'b0;
    endtask

    task automatic test_reset_mid;
        start_op(3'd0, 32'd100, 32'd100);
        tick;
        tick;
        // Now in busy cycle 3; assert reset away from any clock edge.
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_cmp++; if (HI !== 32'h0) begin n_err++; $display("FAIL rstmid_hi: got %h want 0", HI); end
        n_cmp++; if (LO !== 32'h0) begin n_err++; $display("FAIL rstmid_lo: got %h want 0", LO); end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < MC + 2; i++) tick;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_late_busy: got %b want 0", busy); end
        n_cmp++; if (LO !== 32'h0) begin n_err++; $display("FAIL rstmid_late_lo: got %h want 0", LO); end

        start_op(3'd0, 32'd2, 32'd3);
        for (int i = 0; i < MC; i++) tick;
        n_cmp++; if (LO !== 32'd6) begin n_err++; $display("FAIL rst_mult_lo: got %h want 00000006", LO); end
        n_cmp++; if (HI !== 32'd0) begin n_err++; $display("FAIL rst_mult_hi: got %h want 0", HI); end
    endtask

    task automatic test_back_to_back;
        D_use_md = 1'b1;
        start_op(3'd0, 32'd7, 32'd6);
        for (int i = 0; i < MC; i++) begin
            n_cmp++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL b2b_stall[%0d]: got %b want 1", i, stall_req); end
            tick;
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_mult_done: busy got %b want 0", busy); end
        n_cmp++; if (LO !== 32'd42) begin n_err++; $display("FAIL b2b_mult_lo: got %h want 0000002a", LO); end

        // Stall released; DIV issues at t+6. E_start pulses mid-run must be ignored.
        start_op(3'd2, 32'hFFFF_FF9C, 32'd7);
        for (int i = 0; i < DC; i++) begin
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_div_busy[%0d]: got %b want 1", i, busy); end
            if (i == 2) begin
                chk_en = 1'b0; E_mdop = 3'd4; E_A = 32'hDEAD; E_start = 1'b1;
            end else if (i == 3) begin
                E_mdop = 3'd0; E_A = 32'd1; E_B = 32'd1;
            end else if (i == 4) begin
                E_start = 1'b0;
            end
            tick;
            if (i == 4) chk_en = 1'b1;
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_div_done: busy got %b want 0", busy); end
        n_cmp++; if (LO !== 32'hFFFF_FFF2) begin n_err++; $display("FAIL b2b_div_lo: got %h want fffffff2", LO); end
        n_cmp++; if (HI !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL b2b_div_hi: got %h want fffffffe", HI); end
        n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL b2b_stall_after: got %b want 0", stall_req); end
        D_use_md = 1'b0;
    endtask

    initial begin
        test_reset;
        test_mult;
        test_div;
        test_div_corner;
        test_mthi_stall;
        test_reset_mid;
        test_back_to_back;
        tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
